// File: rtl/core_v_mcu_pkg.sv
// Shared MCU definitions: boot ROM arbiter FSM states, the default boot ROM size
// and a small helper for sizing requester index fields.
package core_v_mcu_pkg;

  localparam int unsigned BootRomBytes = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } bootrom_arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bootrom_rr_arb.sv
// Round-robin pick among request bits, searching upward from the slot after last_grant.
// Purely combinational; grant is one-hot (all zero when nothing is requested).
module bootrom_rr_arb
  import core_v_mcu_pkg::*;
#(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   last_grant,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   grant_idx
);

  logic            found;
  int              cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    // off runs to NumReq so last_grant itself is considered last
    for (int off = 1; off <= int'(NumReq); off++) begin
      cand     = (int'(last_grant) + off) % int'(NumReq);
      cand_idx = IdxW'(cand);
      if (!found && req[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_onehot
    assign grant[gi] = found && (grant_idx == IdxW'(gi));
  end

endmodule

// File: rtl/bootrom_arbiter.sv
// Serialises reads from several requesters onto a single boot ROM port, one
// transaction at a time; out-of-range addresses are answered with an error flag.
module bootrom_arbiter
  import core_v_mcu_pkg::*;
#(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RomBytes  = BootRomBytes
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumReq-1:0]                req_valid_i,
  input  logic [NumReq-1:0][AddrWidth-1:0] req_addr_i,
  output logic [NumReq-1:0]                req_ready_o,
  output logic [NumReq-1:0]                rsp_valid_o,
  input  logic [NumReq-1:0]                rsp_ready_i,
  output logic [DataWidth-1:0]             rsp_rdata_o,
  output logic                             rsp_error_o,
  output logic                             rom_req_o,
  output logic [AddrWidth-1:0]             rom_addr_o,
  input  logic [DataWidth-1:0]             rom_rdata_i
);

  localparam int unsigned         IdxW     = idx_width(NumReq);
  localparam logic [AddrWidth-1:0] RomLimit = AddrWidth'(RomBytes);

  bootrom_arb_state_e   state_reg;
  logic [IdxW-1:0]      last_grant_reg;
  logic [IdxW-1:0]      winner_reg;
  logic [DataWidth-1:0] rdata_reg;
  logic                 error_reg;
  logic                 rom_req_reg;
  logic [AddrWidth-1:0] rom_addr_reg;
  logic [NumReq-1:0]    rsp_valid_reg;
  logic                 ready_en_reg;

  logic [NumReq-1:0]    arb_grant;
  logic [IdxW-1:0]      arb_idx;
  logic [NumReq-1:0]    winner_onehot;
  logic [AddrWidth-1:0] sel_addr;
  logic                 accept_en;
  logic                 accept;
  logic                 in_range;

  bootrom_rr_arb #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_arb (
    .req        (req_valid_i),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_winner
    assign winner_onehot[gi] = (winner_reg == IdxW'(gi));
  end

  // ready_en_reg keeps every output quiet for the first cycle after reset
  assign accept_en   = (state_reg == IDLE) && ready_en_reg && !rst_i;
  assign req_ready_o = accept_en ? arb_grant : '0;
  assign accept      = accept_en && (|req_valid_i);
  assign sel_addr    = req_addr_i[arb_idx];
  assign in_range    = (sel_addr < RomLimit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      last_grant_reg <= IdxW'(NumReq - 1);
      winner_reg     <= '0;
      rdata_reg      <= '0;
      error_reg      <= 1'b0;
      rom_req_reg    <= 1'b0;
      rom_addr_reg   <= '0;
      rsp_valid_reg  <= '0;
      ready_en_reg   <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            last_grant_reg <= arb_idx;
            winner_reg     <= arb_idx;
            if (in_range) begin
              rom_req_reg  <= 1'b1;
              rom_addr_reg <= {sel_addr[AddrWidth-1:2], 2'b00};
              state_reg    <= ISSUE;
            end else begin
              rdata_reg     <= '0;
              error_reg     <= 1'b1;
              rsp_valid_reg <= arb_grant;
              state_reg     <= RESP;
            end
          end
        end
        ISSUE: begin
          rom_req_reg  <= 1'b0;
          rom_addr_reg <= '0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          rdata_reg     <= rom_rdata_i;
          error_reg     <= 1'b0;
          rsp_valid_reg <= winner_onehot;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i[winner_reg]) begin
            rsp_valid_reg <= '0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_rdata_o = rdata_reg;
  assign rsp_error_o = error_reg;
  assign rom_req_o   = rom_req_reg;
  assign rom_addr_o  = rom_addr_reg;

endmodule

// File: tb/tb_bootrom_arbiter.sv
// Directed bench for bootrom_arbiter: single reads, alignment, range errors,
// round-robin order, response back-pressure and mid-transaction reset.
module tb_bootrom_arbiter;

  logic             clk;
  logic             rst_i;
  logic [2:0]       req_valid_i;
  logic [2:0][63:0] req_addr_i;
  logic [2:0]       req_ready_o;
  logic [2:0]       rsp_valid_o;
  logic [2:0]       rsp_ready_i;
  logic [31:0]      rsp_rdata_o;
  logic             rsp_error_o;
  logic             rom_req_o;
  logic [63:0]      rom_addr_o;
  logic [31:0]      rom_rdata_i;

  int total = 0;
  int bad   = 0;
  int rom_req_count = 0;

  bootrom_arbiter #(
    .NumReq    (3),
    .AddrWidth (64),
    .DataWidth (32),
    .RomBytes  (4096)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_error_o (rsp_error_o),
    .rom_req_o   (rom_req_o),
    .rom_addr_o  (rom_addr_o),
    .rom_rdata_i (rom_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [63:0] a);
    return (a == 64'h10) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
  endfunction

  // ROM data is only meaningful the cycle after a strobe; junk otherwise
  always @(posedge clk) begin
    rom_rdata_i <= rom_req_o ? rom_word(rom_addr_o) : 32'h0BAD0BAD;
    if (rom_req_o) rom_req_count <= rom_req_count + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid_i = '0;
    rsp_ready_i = '0;
    cyc();
    cyc();
    rst_i = 1'b0;
  endtask

  // One complete read by requester idx; assumes the arbiter is idle and enabled
  task automatic do_read(input int idx, input logic [63:0] addr);
    logic [2:0]  oh;
    logic        err;
    logic [31:0] exp_d;
    int          rc0;
    oh    = 3'b001 << idx;
    err   = (addr >= 64'd4096);
    exp_d = err ? 32'h0 : rom_word(addr & ~64'h3);
    rc0   = rom_req_count;
    req_valid_i = oh;
    req_addr_i[idx] = addr;
    #1;
    chk("accept_ready", req_ready_o, oh);
    cyc();
    req_valid_i = '0;
    req_addr_i[idx] = 64'hFFFF_0000;
    #1;
    if (!err) begin
      chk("issue_rom_req", rom_req_o, 1);
      chk("issue_rom_addr", rom_addr_o, addr & ~64'h3);
      chk("issue_rsp_valid", rsp_valid_o, 0);
      cyc();
      #1;
      chk("wait_rom_req", rom_req_o, 0);
      chk("wait_rom_addr", rom_addr_o, 0);
      chk("wait_rsp_valid", rsp_valid_o, 0);
      cyc();
      #1;
    end
    chk("rsp_valid", rsp_valid_o, oh);
    chk("rsp_rdata", rsp_rdata_o, exp_d);
    chk("rsp_error", rsp_error_o, err);
    rsp_ready_i = oh;
    cyc();
    rsp_ready_i = '0;
    #1;
    chk("rsp_done", rsp_valid_o, 0);
    chk("rom_req_cycles", 64'(rom_req_count - rc0), err ? 64'd0 : 64'd1);
  endtask

  int gk[4];
  int gidx[4];
  int n;

  initial begin
    rst_i = 1'b1;
    req_valid_i = 3'b111;
    req_addr_i = '0;
    rsp_ready_i = '0;
    repeat (3) cyc();
    #1;
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rom_req", rom_req_o, 0);
    chk("rst_rom_addr", rom_addr_o, 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    chk("rst_error", rsp_error_o, 0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_req_ready", req_ready_o, 0);
    req_valid_i = '0;
    cyc();

    do_read(1, 64'h10);
    do_read(0, 64'h13);
    do_read(2, 64'h1000);
    do_read(2, 64'hFFC);
    do_read(0, 64'hFFFF_FFFF_FFFF_FFF0);

    // Round-robin: all valid, all responses accepted immediately
    do_reset();
    req_addr_i = {64'h28, 64'h24, 64'h20};
    req_valid_i = 3'b111;
    rsp_ready_i = 3'b111;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("rr_onehot", {63'd0, $onehot0(req_ready_o)}, 1);
      if (req_ready_o != 3'b000) begin
        if (n < 4) begin
          gk[n] = k;
          gidx[n] = 0;
          for (int b = 0; b < 3; b++) if (req_ready_o[b]) gidx[n] = b;
        end
        n++;
      end
      cyc();
    end
    chk("rr_count", n, 4);
    for (int g = 0; g < 4; g++) begin
      chk("rr_index", gidx[g], (g == 3) ? 0 : g);
      chk("rr_cycle", gk[g], 1 + 4 * g);
    end

    // Back-pressure on requester 0 while requester 1 waits
    do_reset();
    req_addr_i[0] = 64'h10;
    req_valid_i = 3'b001;
    cyc();
    #1;
    chk("bp_accept0", req_ready_o, 3'b001);
    cyc();
    req_valid_i = 3'b010;
    req_addr_i[1] = 64'h40;
    cyc();
    cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rsp_valid", rsp_valid_o, 3'b001);
      chk("bp_rdata", rsp_rdata_o, 32'hDEADBEEF);
      chk("bp_ready1", req_ready_o[1], 0);
      cyc();
    end
    rsp_ready_i = 3'b001;
    cyc();
    rsp_ready_i = '0;
    #1;
    chk("bp_accept1", req_ready_o, 3'b010);
    chk("bp_rsp_done", rsp_valid_o, 0);
    cyc();
    req_valid_i = '0;
    #1;
    chk("bp_rom_addr1", rom_addr_o, 64'h40);
    cyc();
    cyc();
    #1;
    chk("bp_rsp_valid1", rsp_valid_o, 3'b010);
    chk("bp_rdata1", rsp_rdata_o, 32'hC0DE0040);
    rsp_ready_i = 3'b010;
    cyc();
    rsp_ready_i = '0;

    // Reset while waiting on the ROM: read is dropped, priority restarts at 0
    req_valid_i = 3'b100;
    req_addr_i[2] = 64'h80;
    #1;
    chk("ar_accept2", req_ready_o, 3'b100);
    cyc();
    req_valid_i = '0;
    cyc();
    #1;
    chk("ar_in_wait", rom_req_o, 0);
    rst_i = 1'b1;
    #1;
    chk("ar_rst_ready", req_ready_o, 0);
    cyc();
    rst_i = 1'b0;
    req_valid_i = 3'b111;
    #1;
    chk("ar_first_ready", req_ready_o, 0);
    chk("ar_first_rsp", rsp_valid_o, 0);
    chk("ar_rdata", rsp_rdata_o, 0);
    cyc();
    #1;
    chk("ar_grant0", req_ready_o, 3'b001);
    chk("ar_no_rsp", rsp_valid_o, 0);
    req_valid_i = '0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      chk("ar_idle_rsp", rsp_valid_o, 0);
      chk("ar_idle_rom", rom_req_o, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bootrom_arbiter.md
BOOTROM_ARBITER -- requirements
Module: bootrom_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 3, giving the number of requester ports (range 2..8).
REQ-002 SHALL have parameter AddrWidth, default 64, giving the requester and ROM address width.
REQ-003 SHALL have parameter DataWidth, default 32, giving the read data width.
REQ-004 SHALL have parameter RomBytes, default 4096, giving the decoded ROM size in bytes (power of two).
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, the reset: synchronous and active-high.
REQ-007 SHALL have port req_valid_i, input, NumReq, the per-requester read request.
REQ-008 SHALL have port req_addr_i, input, NumReq x AddrWidth, the per-requester byte address, offset from the ROM base.
REQ-009 SHALL have port req_ready_o, output, NumReq, the per-requester grant/accept.
REQ-010 SHALL have port rsp_valid_o, output, NumReq, the per-requester response valid.
REQ-011 SHALL have port rsp_ready_i, input, NumReq, the per-requester response accept.
REQ-012 SHALL have port rsp_rdata_o, output, DataWidth, the shared response data, qualified by rsp_valid_o.
REQ-013 SHALL have port rsp_error_o, output, 1, the shared out-of-range flag, qualified by rsp_valid_o.
REQ-014 SHALL have port rom_req_o, output, 1, the ROM read strobe.
REQ-015 SHALL have port rom_addr_o, output, AddrWidth, the ROM byte address, word-aligned.
REQ-016 SHALL have port rom_rdata_i, input, DataWidth, the ROM data; valid exactly one cycle after rom_req_o.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP; exactly one transaction is in flight at a time.
REQ-018 SHALL, in IDLE only, assert req_ready_o for the single round-robin winner among the asserted req_valid_i bits, combinationally within that cycle; all other req_ready_o bits SHALL be 0.
REQ-019 SHALL search for the round-robin winner starting at index (last_grant+1) mod NumReq; last_grant SHALL update on every accept.
REQ-020 SHALL, on accept with addr < RomBytes, register the winner index and the address with bits [1:0] cleared, then go to ISSUE.
REQ-021 SHALL, on accept with addr >= RomBytes, go directly to RESP with rsp_error_o=1 and rsp_rdata_o=0, and SHALL NOT assert rom_req_o.
REQ-022 SHALL, in ISSUE, drive rom_req_o=1 and rom_addr_o with the registered address for one cycle, then go to WAIT.
REQ-023 SHALL, in WAIT, capture rom_rdata_i into the response register, then go to RESP with rsp_error_o=0.
REQ-024 SHALL, in RESP, assert rsp_valid_o only for the registered winner, holding rsp_rdata_o and rsp_error_o stable until rsp_ready_i of that index is 1.
REQ-025 SHALL return to IDLE on the cycle after the response handshake; a new accept is possible in that IDLE cycle.
REQ-026 SHALL give a latency of 3 cycles from accept to rsp_valid_o on an in-range read, 1 cycle on an error, and a peak throughput of 1 read per 4 cycles.
REQ-027 SHALL ignore rsp_ready_i of non-winning indices and rsp_ready_i outside RESP.
REQ-028 SHALL hold rom_addr_o at 0 whenever rom_req_o=0.
REQ-029 SHALL NOT re-issue the ROM read when requester inputs change after accept; the accepted address is final.

Reset
REQ-030 SHALL, while rst_i=1 at a clock edge, set the state to IDLE, last_grant to NumReq-1 (so index 0 has first priority), the response register to 0 and rsp_error_o to 0.
REQ-031 SHALL drive all outputs to 0 during reset and in the first cycle after it.
REQ-032 SHALL, when reset is asserted mid-transaction, abort the transaction; no rsp_valid_o is produced for it and the requester must re-issue.

Structure
REQ-033 SHALL place the FSM state enum and the default RomBytes constant in the shared core_v_mcu_pkg.
REQ-034 SHALL implement round-robin selection as the sub-module bootrom_rr_arb (inputs: request vector and last_grant; outputs: one-hot grant and index).
REQ-035 SHALL instantiate bootrom_arbiter in the bootrom subsystem between the bus adapters and the bootrom instance.

Verification
REQ-036 Bench SHALL check: a single read by req 1 at addr 0x10 with ROM word 0xDEADBEEF -> rom_req_o exactly 1 cycle, rom_addr_o=0x10, rsp_valid_o[1] 3 cycles after accept, rdata 0xDEADBEEF.
REQ-037 Bench SHALL check: all 3 requesters valid continuously after reset -> grant order 0,1,2,0 and each accept 4 cycles apart.
REQ-038 Bench SHALL check: req 2 reads addr 0x1000 with RomBytes=4096 -> rsp_valid_o[2] 1 cycle after accept, rsp_error_o=1, rdata 0, rom_req_o never asserted.
REQ-039 Bench SHALL check: rsp_ready_i[0] held low 5 cycles while req 1 is valid -> rsp data stable, req_ready_o[1]=0 throughout, req 1 accepted the cycle after the handshake.
REQ-040 Bench SHALL check: unaligned addr 0x13 -> rom_addr_o=0x10.
REQ-041 Bench SHALL check: rst_i pulsed in WAIT -> no rsp_valid_o for that read, state IDLE, next grant goes to index 0.
